block_reduce_ctrl: RTL and testbench
====================================

# block_reduce_ctrl

Parametrised successor to the fixed 4×7-word summing controller. It reduces NUM_BLOCKS consecutive memory blocks, each holding BLOCK_LEN-1 operands. For each block it writes the result into the block's last word. Unlike the previous generation it contains its own accumulator datapath, supports a configurable read latency, selectable reduction mode and overflow reporting, and runs only on a Start handshake instead of looping freely. It sits between the sequencer and the single-port data memory.

## Interface
Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 5, memory address width; BLOCK_LEN*NUM_BLOCKS ≤ 2^ADDR_W (elaboration error otherwise)
- BLOCK_LEN, 8, words per block (operands = BLOCK_LEN-1, ≥2)
- NUM_BLOCKS, 4, blocks per run (≥1)
- RD_LAT, 2, memory read latency in cycles (≥1)

Ports:
- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  run request, sampled only in IDLE
- Mode  in  2  00 sum-wrap, 01 sum-saturate, 10 unsigned max, 11 unsigned min; latched at Start
- Busy  out  1  high in every state except IDLE
- Ready  out  1  one-cycle pulse in DONE
- ReadEnable  out  1  memory read strobe
- ReadData  in  DATA_W  memory read data
- WriteEnable  out  1  memory write strobe
- WriteData  out  DATA_W  result word (accumulator)
- Address  out  ADDR_W  memory address
- Overflow  out  1  sticky: any sum block overflowed in the current/last run

## Operation
- Reset: state IDLE, counters 0, accumulator 0, latched mode 00, Overflow 0. All outputs are 0 while in IDLE.
- IDLE: if Start, latch Mode, clear Overflow, block 0, operand 0 → CLEAR. Otherwise stay.
- CLEAR: accumulator ← all-ones for min mode, else 0 → SEND_ADDR.
- SEND_ADDR: ReadEnable=1, Address=blk*BLOCK_LEN+idx. Go to WAIT_MEM if RD_LAT>1, else ACCUMULATE.
- WAIT_MEM: hold ReadEnable/Address for RD_LAT-1 cycles (wait counter) → ACCUMULATE.
- ACCUMULATE: sample ReadData and update the accumulator per mode. If idx==BLOCK_LEN-2, idx←0 → WRITE_RESULT. Else idx+1 → SEND_ADDR.
- WRITE_RESULT: WriteEnable=1, Address=blk*BLOCK_LEN+BLOCK_LEN-1, WriteData=accumulator → NEXT_BLOCK.
- NEXT_BLOCK: if blk==NUM_BLOCKS-1, blk←0 → DONE. Else blk+1 → CLEAR.
- DONE: Ready=1 → IDLE.
- Arithmetic:
  - Sum-wrap: DATA_W+1-bit add, keep the low DATA_W bits. A carry sets the block overflow.
  - Sum-saturate: clamp at 2^DATA_W-1 on carry and set the block overflow.
  - Max/min: unsigned compare, never overflow.
- Overflow (sticky output) is ORed with the block overflow in WRITE_RESULT.
- Address, ReadEnable and WriteEnable are 0 in every state not listed above as driving them.

## Timing
- Start accepted in cycle 0 (IDLE) → CLEAR in cycle 1.
- ReadData is valid exactly RD_LAT cycles after the SEND_ADDR cycle. It is consumed in ACCUMULATE.
- Per block: 1 + (BLOCK_LEN-1)*(RD_LAT+1) + 2 cycles. Per run: NUM_BLOCKS times that, then DONE.
- Defaults: 24 cycles/block. Ready is high in cycle 97 only, Busy is high in cycles 1–97, IDLE in cycle 98.
- Start while Busy is ignored. Mode changes mid-run are ignored.
- Start held high: DONE→IDLE, then a new run is accepted in that IDLE cycle.
- Reset mid-run has priority over every transition. The next cycle is IDLE with all outputs 0, and no partial result is written.
- Overflow is updated only at WRITE_RESULT edges and cleared only at Start acceptance or Reset.

## Structure
- Package block_reduce_pkg: state enum (IDLE, CLEAR, SEND_ADDR, WAIT_MEM, ACCUMULATE, WRITE_RESULT, NEXT_BLOCK, DONE) and mode encodings.
- Counter widths derive from $clog2 of BLOCK_LEN, NUM_BLOCKS and RD_LAT.
- Sub-module reduce_acc: accumulator register, mode ALU and block-overflow flag, controlled by clear/enable from the FSM.

## Test plan
- Defaults, sum-wrap, every block = 1..7 → writes 28 at addresses 7, 15, 23, 31; Ready a single pulse at cycle 97; Overflow=0.
- Block 0 = {200,100,0,0,0,0,0}: sum-saturate → 255 at address 7, Overflow=1; sum-wrap → 44 at address 7, Overflow=1.
- Block 2 = {5,9,3,250,7,0,1}: max → 250 at address 23; min → 0 at address 23; Overflow stays 0.
- RD_LAT=1 → Ready at cycle 69; RD_LAT=3 → Ready at cycle 125. The read model checks that ReadEnable/Address are held for RD_LAT cycles.
- Reset asserted in a block-1 ACCUMULATE cycle → next cycle all outputs 0 and no write to address 15. The following Start reads from address 0.
- Pulse Start again at cycle 40 and toggle Mode mid-run → no effect on results or timing. Start held high → second run's CLEAR at cycle 99.

Source files
------------

// File: rtl/block_reduce_pkg.sv
// Shared types for the block reduction controller: FSM states, reduction
// mode encodings and a width helper for the internal counters.
package block_reduce_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SEND_ADDR,
        WAIT_MEM,
        ACCUMULATE,
        WRITE_RESULT,
        NEXT_BLOCK,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_SUM_WRAP = 2'b00,
        MODE_SUM_SAT  = 2'b01,
        MODE_MAX      = 2'b10,
        MODE_MIN      = 2'b11
    } mode_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int widthOf(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_reduce_ctrl_acc.sv
// Accumulator datapath: one register, the mode ALU (wrap/saturating sum,
// unsigned max/min) and a per-block overflow flag. The controller clears it
// at the start of every block and enables it once per operand.
module reduce_acc
    import block_reduce_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_blockOvf
);

    logic [DATA_W-1:0] r_acc;
    logic              r_blockOvf;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_nextAcc;
    logic              w_carry;

    // Mode ALU: next accumulator value and whether this step carried out.
    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, i_data};
        w_nextAcc = r_acc;
        w_carry   = 1'b0;
        case (i_mode)
            MODE_SUM_WRAP: begin
                w_nextAcc = w_sum[DATA_W-1:0];
                w_carry   = w_sum[DATA_W];
            end
            MODE_SUM_SAT: begin
                w_nextAcc = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
                w_carry   = w_sum[DATA_W];
            end
            MODE_MAX: w_nextAcc = (i_data > r_acc) ? i_data : r_acc;
            MODE_MIN: w_nextAcc = (i_data < r_acc) ? i_data : r_acc;
            default:  w_nextAcc = r_acc;
        endcase
    end

    // Accumulator and block overflow; min mode starts from all-ones so the first operand always wins.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_acc      <= '0;
            r_blockOvf <= 1'b0;
        end else if (i_clear) begin
            r_acc      <= (i_mode == MODE_MIN) ? {DATA_W{1'b1}} : '0;
            r_blockOvf <= 1'b0;
        end else if (i_enable) begin
            r_acc      <= w_nextAcc;
            r_blockOvf <= r_blockOvf | w_carry;
        end
    end

    assign o_acc      = r_acc;
    assign o_blockOvf = r_blockOvf;

endmodule

// File: rtl/block_reduce_ctrl.sv
// Block reduction controller: on Start, reduces NUM_BLOCKS memory blocks of
// BLOCK_LEN-1 operands each and writes every result into the block's last
// word, talking to a single-port memory with RD_LAT cycles of read latency.
module block_reduce_ctrl
    import block_reduce_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int BLOCK_LEN  = 8,
    parameter int NUM_BLOCKS = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    output logic              o_busy,
    output logic              o_ready,
    output logic              o_readEnable,
    input  logic [DATA_W-1:0] i_readData,
    output logic              o_writeEnable,
    output logic [DATA_W-1:0] o_writeData,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_overflow
);

    localparam int IDX_W  = widthOf(BLOCK_LEN);
    localparam int BLK_W  = widthOf(NUM_BLOCKS);
    localparam int WAIT_W = widthOf(RD_LAT);

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(BLOCK_LEN - 2);
    localparam logic [BLK_W-1:0]  BLK_LAST    = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [ADDR_W-1:0] BLOCK_LEN_A = ADDR_W'(BLOCK_LEN);
    localparam logic [ADDR_W-1:0] RESULT_OFS  = ADDR_W'(BLOCK_LEN - 1);

    if (BLOCK_LEN < 2) begin : g_badBlockLen
        $error("block_reduce_ctrl: BLOCK_LEN must be at least 2");
    end
    if (NUM_BLOCKS < 1) begin : g_badNumBlocks
        $error("block_reduce_ctrl: NUM_BLOCKS must be at least 1");
    end
    if (RD_LAT < 1) begin : g_badRdLat
        $error("block_reduce_ctrl: RD_LAT must be at least 1");
    end
    if (BLOCK_LEN * NUM_BLOCKS > 2 ** ADDR_W) begin : g_badAddrW
        $error("block_reduce_ctrl: blocks do not fit in the address space");
    end

    state_e            r_state;
    state_e            w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [BLK_W-1:0]  r_blk;
    logic [WAIT_W-1:0] r_wait;
    logic [1:0]        r_mode;
    logic              r_overflow;

    logic              w_busy;
    logic              w_ready;
    logic              w_readEnable;
    logic              w_writeEnable;
    logic [ADDR_W-1:0] w_address;
    logic [ADDR_W-1:0] w_blockBase;
    logic              w_accClear;
    logic              w_accEnable;
    logic [DATA_W-1:0] w_acc;
    logic              w_blockOvf;

    // State register; reset wins over every transition.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state outputs; anything not driven in a state stays 0.
    always_comb begin
        w_next        = r_state;
        w_busy        = 1'b1;
        w_ready       = 1'b0;
        w_readEnable  = 1'b0;
        w_writeEnable = 1'b0;
        w_address     = '0;
        w_accClear    = 1'b0;
        w_accEnable   = 1'b0;
        w_blockBase   = ADDR_W'(r_blk) * BLOCK_LEN_A;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_next = CLEAR;
                end
            end
            CLEAR: begin
                w_accClear = 1'b1;
                w_next     = SEND_ADDR;
            end
            SEND_ADDR: begin
                w_readEnable = 1'b1;
                w_address    = w_blockBase + ADDR_W'(r_idx);
                w_next       = (RD_LAT > 1) ? WAIT_MEM : ACCUMULATE;
            end
            WAIT_MEM: begin
                w_readEnable = 1'b1;
                w_address    = w_blockBase + ADDR_W'(r_idx);
                if (r_wait == WAIT_LAST) begin
                    w_next = ACCUMULATE;
                end
            end
            ACCUMULATE: begin
                w_accEnable = 1'b1;
                w_next      = (r_idx == IDX_LAST) ? WRITE_RESULT : SEND_ADDR;
            end
            WRITE_RESULT: begin
                w_writeEnable = 1'b1;
                w_address     = w_blockBase + RESULT_OFS;
                w_next        = NEXT_BLOCK;
            end
            NEXT_BLOCK: begin
                w_next = (r_blk == BLK_LAST) ? DONE : CLEAR;
            end
            DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand/block/wait counters, latched mode and the sticky run overflow.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_idx      <= '0;
            r_blk      <= '0;
            r_wait     <= '0;
            r_mode     <= MODE_SUM_WRAP;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mode     <= i_mode;
                        r_overflow <= 1'b0;
                        r_blk      <= '0;
                        r_idx      <= '0;
                    end
                end
                SEND_ADDR:    r_wait <= '0;
                WAIT_MEM:     r_wait <= r_wait + 1'b1;
                ACCUMULATE:   r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                WRITE_RESULT: r_overflow <= r_overflow | w_blockOvf;
                NEXT_BLOCK:   r_blk  <= (r_blk == BLK_LAST) ? '0 : r_blk + 1'b1;
                default: ;
            endcase
        end
    end

    reduce_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_clear    (w_accClear),
        .i_enable   (w_accEnable),
        .i_mode     (r_mode),
        .i_data     (i_readData),
        .o_acc      (w_acc),
        .o_blockOvf (w_blockOvf)
    );

    assign o_busy        = w_busy;
    assign o_ready       = w_ready;
    assign o_readEnable  = w_readEnable;
    assign o_writeEnable = w_writeEnable;
    assign o_address     = w_address;
    assign o_writeData   = w_writeEnable ? w_acc : '0;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_block_reduce_ctrl.sv
// Scoreboard bench for block_reduce_ctrl: three instances with read latency
// 1, 2 and 3 share one memory image; expected writes and Ready pulses are
// queued when a run is started and matched when the DUT produces them.
module tb_block_reduce_ctrl;

    typedef struct packed {
        int   cyc;
        logic ovf;
    } rdy_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start = 3'b000;
    logic [1:0] mode  = 2'b00;
    int         cyc   = 0;

    logic [7:0]  mem [32];
    int unsigned wrQ [3][$];
    rdy_t        rdyQ[3][$];
    int          nextRd[3];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Cycle index; after a tick it names the cycle currently in progress.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;

        logic       busy, ready, re, we, ovf;
        logic [7:0] wdata;
        logic [7:0] rdata = 8'hA5;
        logic [4:0] addr;
        logic [4:0] launchAddr = '0;
        logic       prevRe  = 1'b0;
        logic       prevRdy = 1'b0;
        int         runLen  = 0;

        block_reduce_ctrl #(
            .DATA_W     (8),
            .ADDR_W     (5),
            .BLOCK_LEN  (8),
            .NUM_BLOCKS (4),
            .RD_LAT     (LAT)
        ) u_dut (
            .i_clock       (clock),
            .i_reset       (reset),
            .i_start       (start[g]),
            .i_mode        (mode),
            .o_busy        (busy),
            .o_ready       (ready),
            .o_readEnable  (re),
            .i_readData    (rdata),
            .o_writeEnable (we),
            .o_writeData   (wdata),
            .o_address     (addr),
            .o_overflow    (ovf)
        );

        // Memory read model, write scoreboard and Ready checks, mid-cycle.
        always @(negedge clock) begin
            if (reset) begin
                prevRe  = 1'b0;
                prevRdy = 1'b0;
                runLen  = 0;
                rdata   = 8'hA5;
            end else begin
                rdata = 8'hA5;
                if (re) begin
                    if (!prevRe) begin
                        checkOutput($sformatf("rdAddr%0d", g), addr, nextRd[g]);
                        launchAddr = addr;
                        runLen     = 1;
                        nextRd[g]  = ((nextRd[g] % 8 == 6) ? nextRd[g] + 2 : nextRd[g] + 1) % 32;
                    end else begin
                        runLen++;
                        checkOutput($sformatf("rdHold%0d", g), addr, launchAddr);
                    end
                end else if (prevRe) begin
                    checkOutput($sformatf("rdLen%0d", g), runLen, LAT);
                    rdata = mem[launchAddr];
                end
                prevRe = re;

                if (we) begin
                    checkOutput($sformatf("wrAvail%0d", g), wrQ[g].size() > 0, 1);
                    if (wrQ[g].size() > 0) begin
                        int unsigned e;
                        e = wrQ[g].pop_front();
                        checkOutput($sformatf("wrAddr%0d", g), addr, e >> 8);
                        checkOutput($sformatf("wrData%0d", g), wdata, e & 8'hFF);
                    end
                end

                if (ready) begin
                    checkOutput($sformatf("rdyAvail%0d", g), rdyQ[g].size() > 0, 1);
                    if (rdyQ[g].size() > 0) begin
                        rdy_t r;
                        r = rdyQ[g].pop_front();
                        checkOutput($sformatf("rdyCycle%0d", g), cyc, r.cyc);
                        checkOutput($sformatf("rdyOvf%0d", g), ovf, r.ovf);
                        checkOutput($sformatf("rdyBusy%0d", g), busy, 1);
                    end
                end
                if (prevRdy) begin
                    checkOutput($sformatf("idleOut%0d", g), {busy, ready, re, we, addr, wdata}, 0);
                end
                prevRdy = ready;
            end
        end
    end

    // Independent reference: result and overflow of one block under a mode.
    function automatic void blockResult(input int b, input logic [1:0] m, output int data, output bit o);
        int total = 0;
        int mx    = 0;
        int mn    = 255;
        for (int i = 0; i < 7; i++) begin
            int v;
            v = int'(mem[b * 8 + i]);
            total += v;
            if (v > mx) mx = v;
            if (v < mn) mn = v;
        end
        o = 1'b0;
        case (m)
            2'b00:   begin data = total % 256; o = (total > 255); end
            2'b01:   begin data = (total > 255) ? 255 : total; o = (total > 255); end
            2'b10:   data = mx;
            default: data = mn;
        endcase
    endfunction

    task automatic fillDefault;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 7; i++) mem[b * 8 + i] = 8'(i + 1);
            mem[b * 8 + 7] = 8'h00;
        end
    endtask

    // Queue the writes (first nBlk blocks) and optionally the Ready pulse of a run accepted in cycle s.
    task automatic pushExpect(input logic [2:0] mask, input logic [1:0] m, input int nBlk, input bit withReady, input int s);
        for (int g = 0; g < 3; g++) begin
            if (mask[g]) begin
                bit runOvf = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    int d;
                    bit o;
                    blockResult(b, m, d, o);
                    runOvf |= o;
                    if (b < nBlk) wrQ[g].push_back(unsigned'((b * 8 + 7) << 8 | d));
                end
                if (withReady) rdyQ[g].push_back('{cyc: s + 4 * (3 + 7 * (g + 2)) + 1, ovf: runOvf});
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0] mask, input logic [1:0] m, input int nBlk, input bit withReady, input bit hold);
        for (int g = 0; g < 3; g++) if (mask[g]) nextRd[g] = 0;
        pushExpect(mask, m, nBlk, withReady, cyc);
        mode  = m;
        start = mask;
        tick;
        if (!hold) start = 3'b000;
    endtask

    function automatic int pending;
        int n = 0;
        for (int g = 0; g < 3; g++) n += wrQ[g].size() + rdyQ[g].size();
        return n;
    endfunction

    task automatic waitIdle(input int budget);
        int left = budget;
        while (pending() != 0 && left > 0) begin
            tick;
            left--;
        end
        checkOutput("timeout", pending(), 0);
        tick;
        tick;
    endtask

    // Test sequence.
    initial begin
        fillDefault();
        for (int g = 0; g < 3; g++) nextRd[g] = 0;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        checkOutput("rstOut1", {g_dut[1].busy, g_dut[1].ready, g_dut[1].re, g_dut[1].we,
                                g_dut[1].addr, g_dut[1].wdata, g_dut[1].ovf}, 0);
        checkOutput("rstBusy0", {g_dut[0].busy, g_dut[0].re, g_dut[0].we, g_dut[0].ovf}, 0);
        checkOutput("rstBusy2", {g_dut[2].busy, g_dut[2].re, g_dut[2].we, g_dut[2].ovf}, 0);

        $display("[TB] sum-wrap on 1..7, all read latencies");
        applyStimulus(3'b111, 2'b00, 4, 1'b1, 1'b0);
        waitIdle(400);

        $display("[TB] block 0 overflow: saturate then wrap");
        mem[0] = 8'd200;
        mem[1] = 8'd100;
        for (int i = 2; i < 7; i++) mem[i] = 8'd0;
        applyStimulus(3'b010, 2'b01, 4, 1'b1, 1'b0);
        waitIdle(300);
        applyStimulus(3'b010, 2'b00, 4, 1'b1, 1'b0);
        waitIdle(300);

        $display("[TB] max and min on block 2");
        fillDefault();
        mem[16] = 8'd5;   mem[17] = 8'd9; mem[18] = 8'd3; mem[19] = 8'd250;
        mem[20] = 8'd7;   mem[21] = 8'd0; mem[22] = 8'd1;
        applyStimulus(3'b010, 2'b10, 4, 1'b1, 1'b0);
        waitIdle(300);
        applyStimulus(3'b010, 2'b11, 4, 1'b1, 1'b0);
        waitIdle(300);

        $display("[TB] reset in block 1 accumulate");
        fillDefault();
        applyStimulus(3'b010, 2'b00, 1, 1'b0, 1'b0);
        repeat (27) tick;
        reset = 1'b1;
        tick;
        checkOutput("midRstOut", {g_dut[1].busy, g_dut[1].ready, g_dut[1].re, g_dut[1].we,
                                  g_dut[1].addr, g_dut[1].wdata, g_dut[1].ovf}, 0);
        checkOutput("midRstPend", pending(), 0);
        reset = 1'b0;
        tick;
        applyStimulus(3'b010, 2'b00, 4, 1'b1, 1'b0);
        waitIdle(300);

        $display("[TB] Start and Mode changes during a run");
        applyStimulus(3'b010, 2'b00, 4, 1'b1, 1'b0);
        repeat (9) tick;
        mode = 2'b11;
        repeat (30) tick;
        start = 3'b010;
        mode  = 2'b10;
        tick;
        start = 3'b000;
        mode  = 2'b01;
        waitIdle(300);

        $display("[TB] Start held high across DONE");
        applyStimulus(3'b010, 2'b00, 4, 1'b1, 1'b1);
        pushExpect(3'b010, 2'b00, 4, 1'b1, cyc + 97);
        repeat (98) tick;
        checkOutput("heldClearBusy", g_dut[1].busy, 1);
        start = 3'b000;
        waitIdle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
